// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement ROB; define ROB_STATS_EN for commit/flush counters
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int PREG_W = 7,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [TAG_W-1:0]  alloc_tag,
  input  logic [PC_W-1:0]   alloc_pc,
  input  logic [PREG_W-1:0] alloc_pd_new,
  input  logic [PREG_W-1:0] alloc_pd_old,
  input  logic              alloc_is_br,
  input  logic              cmpl_valid,
  input  logic [TAG_W-1:0]  cmpl_tag,
  input  logic              cmpl_mispredict,
  output logic              free_en,
  output logic [PREG_W-1:0] free_preg,
  output logic              mispredict,
  output logic [4:0]        mispredict_tag,
  output logic              hit,
  output logic [TAG_W-1:0]  hit_tag,
  output logic              commit_valid,
  output logic [PC_W-1:0]   commit_pc,
`ifdef ROB_STATS_EN
  output logic [31:0]       stat_commits,
  output logic [15:0]       stat_flushes,
`endif
  output logic              tag_err
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W + 1)'(DEPTH);

  // Entry control bits (reset) and payload (no reset, only read while valid)
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [DEPTH-1:0]  is_br_q;
  logic [PC_W-1:0]   pc_q     [DEPTH];
  logic [PREG_W-1:0] pd_new_q [DEPTH];
  logic [PREG_W-1:0] pd_old_q [DEPTH];

  logic [TAG_W-1:0]  head_q, head_d;
  logic [TAG_W-1:0]  tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;

  // Registered output pulses
  logic              free_en_q;
  logic [PREG_W-1:0] free_preg_q;
  logic              mispredict_q;
  logic [4:0]        mispredict_tag_q;
  logic              hit_q;
  logic [TAG_W-1:0]  hit_tag_q;
  logic              commit_valid_q;
  logic [PC_W-1:0]   commit_pc_q;
  logic              tag_err_q;

  logic              cmpl_hit;
  logic              flush_pending;
  logic              br_hit;
  logic              commit_fire;
  logic              alloc_fire;
  logic [TAG_W-1:0]  br_rel;

  // A completion only counts on a live entry that has not finished yet
  assign cmpl_hit      = cmpl_valid && valid_q[cmpl_tag] && !done_q[cmpl_tag];
  assign flush_pending = cmpl_hit && is_br_q[cmpl_tag] && cmpl_mispredict;
  assign br_hit        = cmpl_hit && is_br_q[cmpl_tag] && !cmpl_mispredict;
  assign commit_fire   = valid_q[head_q] && done_q[head_q];
  assign alloc_ready   = (count_q != FULL_CNT) && !mispredict_q && !flush_pending;
  assign alloc_fire    = alloc_valid && alloc_ready;
  // Age of the resolving branch measured from the oldest entry
  assign br_rel        = cmpl_tag - head_q;

  // Next-state for entry flags and pointers: commit, completion, flush, then allocation
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + {{TAG_W{1'b0}}, alloc_fire} - {{TAG_W{1'b0}}, commit_fire};
    if (commit_fire) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    if (cmpl_hit) begin
      done_d[cmpl_tag] = 1'b1;
    end
    if (flush_pending) begin
      // Everything strictly younger than the branch (head-relative age) is discarded
      for (int i = 0; i < DEPTH; i++) begin
        if ((TAG_W'(i) - head_q) > br_rel) begin
          valid_d[i] = 1'b0;
        end
      end
      tail_d  = cmpl_tag + 1'b1;
      count_d = {1'b0, br_rel} + 1'b1 - {{TAG_W{1'b0}}, commit_fire};
    end
    if (alloc_fire) begin
      valid_d[alloc_tag] = 1'b1;
      done_d[alloc_tag]  = 1'b0;
      tail_d             = alloc_tag + 1'b1;
    end
  end

  // Control state and registered outputs, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q          <= '0;
      done_q           <= '0;
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      free_en_q        <= 1'b0;
      free_preg_q      <= '0;
      mispredict_q     <= 1'b0;
      mispredict_tag_q <= '0;
      hit_q            <= 1'b0;
      hit_tag_q        <= '0;
      commit_valid_q   <= 1'b0;
      commit_pc_q      <= '0;
      tag_err_q        <= 1'b0;
    end else begin
      valid_q          <= valid_d;
      done_q           <= done_d;
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      commit_valid_q   <= commit_fire;
      commit_pc_q      <= commit_fire ? pc_q[head_q] : '0;
      free_en_q        <= commit_fire && (pd_new_q[head_q] != '0);
      free_preg_q      <= commit_fire ? pd_old_q[head_q] : '0;
      hit_q            <= br_hit;
      hit_tag_q        <= br_hit ? cmpl_tag : '0;
      mispredict_q     <= flush_pending;
      mispredict_tag_q <= flush_pending ? 5'({1'b0, cmpl_tag}) : '0;
      if (alloc_fire && (alloc_tag != tail_q)) begin
        tag_err_q <= 1'b1;
      end
    end
  end

  // Payload capture on allocation
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      is_br_q[alloc_tag]  <= alloc_is_br;
      pc_q[alloc_tag]     <= alloc_pc;
      pd_new_q[alloc_tag] <= alloc_pd_new;
      pd_old_q[alloc_tag] <= alloc_pd_old;
    end
  end

  assign free_en        = free_en_q;
  assign free_preg      = free_preg_q;
  assign mispredict     = mispredict_q;
  assign mispredict_tag = mispredict_tag_q;
  assign hit            = hit_q;
  assign hit_tag        = hit_tag_q;
  assign commit_valid   = commit_valid_q;
  assign commit_pc      = commit_pc_q;
  assign tag_err        = tag_err_q;

`ifdef ROB_STATS_EN
  logic [31:0] stat_commits_q;
  logic [15:0] stat_flushes_q;

  // Saturating event counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_commits_q <= '0;
      stat_flushes_q <= '0;
    end else begin
      if (commit_fire && (stat_commits_q != '1)) begin
        stat_commits_q <= stat_commits_q + 1'b1;
      end
      if (flush_pending && (stat_flushes_q != '1)) begin
        stat_flushes_q <= stat_flushes_q + 1'b1;
      end
    end
  end

  assign stat_commits = stat_commits_q;
  assign stat_flushes = stat_flushes_q;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - randomized self-checking bench for reorder_buffer
`timescale 1ns/1ps
module tb_reorder_buffer;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        alloc_valid, alloc_ready, alloc_is_br;
  logic [3:0]  alloc_tag;
  logic [31:0] alloc_pc;
  logic [6:0]  alloc_pd_new, alloc_pd_old;
  logic        cmpl_valid, cmpl_mispredict;
  logic [3:0]  cmpl_tag;
  logic        free_en, mispredict, hit, commit_valid, tag_err;
  logic [6:0]  free_preg;
  logic [4:0]  mispredict_tag;
  logic [3:0]  hit_tag;
  logic [31:0] commit_pc;
`ifdef ROB_STATS_EN
  logic [31:0] stat_commits;
  logic [15:0] stat_flushes;
`endif

  always #5 clk = ~clk;

  reorder_buffer #(.DEPTH(16), .TAG_W(4), .PREG_W(7), .PC_W(32)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_pc(alloc_pc), .alloc_pd_new(alloc_pd_new), .alloc_pd_old(alloc_pd_old),
    .alloc_is_br(alloc_is_br),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .cmpl_mispredict(cmpl_mispredict),
    .free_en(free_en), .free_preg(free_preg),
    .mispredict(mispredict), .mispredict_tag(mispredict_tag),
    .hit(hit), .hit_tag(hit_tag),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
`ifdef ROB_STATS_EN
    .stat_commits(stat_commits), .stat_flushes(stat_flushes),
`endif
    .tag_err(tag_err)
  );

  // Reference model: program-ordered list of in-flight instructions
  typedef struct {
    logic [3:0]  tag;
    logic [31:0] pc;
    logic [6:0]  pd_new;
    logic [6:0]  pd_old;
    logic        is_br;
    logic        done;
  } ent_t;

  ent_t        rob_q[$];
  logic [3:0]  m_tail;
  logic        m_mp_out;
  logic        m_tag_err;
  int          m_commits;
  int          m_flushes;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_clear();
    rob_q.delete();
    m_tail    = 4'd0;
    m_mp_out  = 1'b0;
    m_tag_err = 1'b0;
    m_commits = 0;
    m_flushes = 0;
  endtask

  task automatic drive_idle();
    alloc_valid = 1'b0; alloc_tag = '0; alloc_pc = '0; alloc_pd_new = '0;
    alloc_pd_old = '0; alloc_is_br = 1'b0;
    cmpl_valid = 1'b0; cmpl_tag = '0; cmpl_mispredict = 1'b0;
  endtask

  task automatic check_cleared(input string where);
    check({where, ".alloc_ready"}, alloc_ready, 1'b1);
    check({where, ".commit_valid"}, commit_valid, 1'b0);
    check({where, ".commit_pc"}, commit_pc, 32'd0);
    check({where, ".free_en"}, free_en, 1'b0);
    check({where, ".free_preg"}, free_preg, 7'd0);
    check({where, ".mispredict"}, mispredict, 1'b0);
    check({where, ".mispredict_tag"}, mispredict_tag, 5'd0);
    check({where, ".hit"}, hit, 1'b0);
    check({where, ".hit_tag"}, hit_tag, 4'd0);
    check({where, ".tag_err"}, tag_err, 1'b0);
`ifdef ROB_STATS_EN
    check({where, ".stat_commits"}, stat_commits, 32'd0);
    check({where, ".stat_flushes"}, stat_flushes, 16'd0);
`endif
  endtask

  // Called at a falling edge; returns at the next falling edge with reset released
  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    #1;
    check_cleared("reset");
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  // One clock: drive at the falling edge, predict, check registered outputs one edge later
  task automatic cycle(input logic av, input logic [3:0] atag, input logic [31:0] apc,
                       input logic [6:0] pnew, input logic [6:0] pold, input logic abr,
                       input logic cv, input logic [3:0] ctag, input logic cm);
    logic exp_ready, flush_now, e_commit, e_hit, e_mp;
    ent_t c, e;
    int   bidx;
    alloc_valid = av; alloc_tag = atag; alloc_pc = apc; alloc_pd_new = pnew;
    alloc_pd_old = pold; alloc_is_br = abr;
    cmpl_valid = cv; cmpl_tag = ctag; cmpl_mispredict = cm;
    #1;
    bidx = -1;
    if (cv) begin
      for (int k = 0; k < rob_q.size(); k++) begin
        if (rob_q[k].tag == ctag && !rob_q[k].done) bidx = k;
      end
    end
    flush_now = (bidx >= 0) && rob_q[bidx].is_br && cm;
    e_hit     = (bidx >= 0) && rob_q[bidx].is_br && !cm;
    e_mp      = flush_now;
    exp_ready = (rob_q.size() < DEPTH) && !m_mp_out && !flush_now;
    check("alloc_ready", alloc_ready, exp_ready);
    e_commit = (rob_q.size() > 0) && rob_q[0].done;
    c = '{tag: 4'd0, pc: 32'd0, pd_new: 7'd0, pd_old: 7'd0, is_br: 1'b0, done: 1'b0};
    if (e_commit) c = rob_q[0];
    if (bidx >= 0) begin
      e = rob_q[bidx];
      e.done = 1'b1;
      rob_q[bidx] = e;
    end
    if (flush_now) begin
      while (rob_q.size() > bidx + 1) rob_q.delete(rob_q.size() - 1);
      m_tail = ctag + 4'd1;
      m_flushes++;
    end
    if (e_commit) begin
      rob_q.delete(0);
      m_commits++;
    end
    if (av && exp_ready) begin
      if (atag != m_tail) m_tag_err = 1'b1;
      rob_q.push_back('{tag: atag, pc: apc, pd_new: pnew, pd_old: pold, is_br: abr, done: 1'b0});
      m_tail = atag + 4'd1;
    end
    m_mp_out = e_mp;
    @(posedge clk);
    @(negedge clk);
    check("commit_valid", commit_valid, e_commit);
    if (e_commit) begin
      check("commit_pc", commit_pc, c.pc);
      check("free_en", free_en, c.pd_new != 7'd0);
      if (c.pd_new != 7'd0) check("free_preg", free_preg, c.pd_old);
    end else begin
      check("free_en_idle", free_en, 1'b0);
    end
    check("hit", hit, e_hit);
    if (e_hit) check("hit_tag", hit_tag, ctag);
    check("mispredict", mispredict, e_mp);
    if (e_mp) check("mispredict_tag", mispredict_tag, {1'b0, ctag});
    check("tag_err", tag_err, m_tag_err);
`ifdef ROB_STATS_EN
    check("stat_commits", stat_commits, m_commits);
    check("stat_flushes", stat_flushes, m_flushes);
`endif
  endtask

  task automatic idle();
    cycle(1'b0, 4'd0, 32'd0, 7'd0, 7'd0, 1'b0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic alloc(input logic [3:0] t, input logic [31:0] pc, input logic [6:0] pn,
                       input logic [6:0] po, input logic br);
    cycle(1'b1, t, pc, pn, po, br, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic cmpl(input logic [3:0] t, input logic mis);
    cycle(1'b0, 4'd0, 32'd0, 7'd0, 7'd0, 1'b0, 1'b1, t, mis);
  endtask

  initial begin
    drive_idle();
    model_clear();
    do_reset();

    // In-order commit of out-of-order completions, free list return
    alloc(4'd0, 32'h100, 7'd33, 7'd5, 1'b0);
    alloc(4'd1, 32'h104, 7'd34, 7'd6, 1'b0);
    alloc(4'd2, 32'h108, 7'd0,  7'd7, 1'b0);
    cmpl(4'd2, 1'b0);
    cmpl(4'd0, 1'b0);
    cmpl(4'd1, 1'b0);
    repeat (4) idle();

    // Fill to 16, blocked alloc, commit frees a slot, wrap to tag 0
    do_reset();
    for (int t = 0; t < 16; t++) alloc(4'(t), 32'h200 + 32'(4 * t), 7'(t + 1), 7'(t), 1'b0);
    alloc(4'd0, 32'h300, 7'd9, 7'd9, 1'b0);
    cmpl(4'd0, 1'b0);
    idle();
    alloc(4'd0, 32'h304, 7'd10, 7'd11, 1'b0);

    // Randomized traffic continuing from the full-buffer state
    for (int n = 0; n < 600; n++) begin
      logic       r_av, r_br, r_cv, r_cm;
      logic [3:0] r_ct;
      logic [6:0] r_pn;
      r_av = ($urandom % 4) != 0;
      r_pn = (($urandom % 5) == 0) ? 7'd0 : 7'($urandom);
      r_br = ($urandom % 4) == 0;
      r_cv = ($urandom % 3) != 0;
      if (rob_q.size() > 0 && ($urandom % 4) != 0) r_ct = rob_q[$urandom % rob_q.size()].tag;
      else r_ct = 4'($urandom);
      r_cm = ($urandom % 3) == 0;
      cycle(r_av, m_tail, $urandom, r_pn, 7'($urandom), r_br, r_cv, r_ct, r_cm);
    end

    // Correctly predicted branch at tag 4
    do_reset();
    for (int t = 0; t < 5; t++) alloc(4'(t), 32'h400 + 32'(4 * t), 7'(t + 40), 7'(t), t == 4);
    cmpl(4'd4, 1'b0);
    repeat (2) idle();

    // Mispredicted branch at tag 2 flushes 3..5, then out-of-sequence tag 7
    do_reset();
    for (int t = 0; t < 6; t++) alloc(4'(t), 32'h500 + 32'(4 * t), 7'(t + 50), 7'(t), t == 2);
    cmpl(4'd2, 1'b1);
    idle();
    cmpl(4'd4, 1'b0);
    alloc(4'd7, 32'h600, 7'd60, 7'd1, 1'b0);
    repeat (3) idle();
    alloc(4'd8, 32'h604, 7'd61, 7'd2, 1'b0);
    check("tag_err_before_reset", tag_err, 1'b1);

    // Asynchronous reset with five entries still pending
    #2;
    reset = 1'b1;
    #1;
    check_cleared("async_reset");
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement buffer; the consumer end of the rename stage's ROB interface.
- Takes renamed instructions tagged by rename's rob_tag counter and marks them done on functional-unit completion.
- Retires at most one instruction per cycle, in order, and returns the retiring instruction's old physical register to the free list (write_en / rob_data_in).
- Generates the mispredict / mispredict_tag / hit pulses that rename uses to restore or release checkpoints.

Parameters:
- DEPTH, 16, number of entries; equals the rename tag space (power of 2).
- TAG_W, 4, log2(DEPTH).
- PREG_W, 7, physical register index width.
- PC_W, 32, PC width.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- alloc_valid  in  1  rename output valid
- alloc_ready  out  1  ROB can accept (drives rename ready_out)
- alloc_tag  in  TAG_W  rob_tag from rename
- alloc_pc  in  PC_W  instruction PC
- alloc_pd_new  in  PREG_W  new physical dest; 0 = no destination
- alloc_pd_old  in  PREG_W  previous mapping of rd
- alloc_is_br  in  1  branch or jalr
- cmpl_valid  in  1  FU completion strobe
- cmpl_tag  in  TAG_W  completing tag
- cmpl_mispredict  in  1  branch resolved wrong (meaningful only for branch entries)
- free_en  out  1  to rename write_en
- free_preg  out  PREG_W  to rename rob_data_in
- mispredict  out  1  flush pulse
- mispredict_tag  out  5  {1'b0, tag} of mispredicted branch
- hit  out  1  correct-prediction pulse
- hit_tag  out  TAG_W  tag for hit
- commit_valid  out  1  retirement strobe
- commit_pc  out  PC_W  retired PC
- tag_err  out  1  sticky: alloc_tag != internal tail

Behaviour:
- Entry fields: valid, done, is_br, pc, pd_new, pd_old.
- State: head, tail (TAG_W, wrap modulo DEPTH), count (TAG_W+1).
- Reset: all entries invalid, head = tail = count = 0. Every output is 0; alloc_ready is combinational and therefore reads 1.
- alloc_ready = (count != DEPTH) && !mispredict && !flush_pending.
- Allocation: when alloc_valid && alloc_ready, write entry[alloc_tag] with done = 0 and set tail <= alloc_tag + 1.
  - If alloc_tag != tail, set tag_err (cleared only by reset); the write still uses alloc_tag.
- Completion: cmpl_valid on a valid entry sets done.
  - Completion on an invalid entry is ignored.
  - Completion on an already-done entry is ignored.
- Branch resolution, registered, outputs valid the next cycle:
  - Correct branch: hit = 1, hit_tag = cmpl_tag, for one cycle.
  - Mispredicted branch: mispredict = 1, mispredict_tag = {0, cmpl_tag}, for one cycle.
  - Mispredict flush: in the same edge, invalidate all entries strictly younger than cmpl_tag (from cmpl_tag+1 up to tail-1, wrap-aware), set tail <= cmpl_tag + 1, and set count = distance(head, cmpl_tag) + 1.
  - Younger pd_new registers are NOT freed; rename restores them from its checkpoint.
  - flush_pending is high in the completion cycle, so an alloc in that cycle is dropped.
- Commit: when entry[head] is valid && done, then on the next edge:
  - Retire the entry and advance head.
  - commit_valid = 1, commit_pc = pc.
  - free_en = (pd_new != 0), free_preg = pd_old.
  - These outputs are registered with 1-cycle latency and are otherwise 0 each cycle.
- Simultaneous events:
  - Commit of head and allocation in the same cycle: count unchanged.
  - Commit and mispredict in the same cycle: the head commit proceeds, because head is older than or equal to the branch.
  - A branch cannot both complete and commit in one cycle; done is seen the following cycle.
- Full: count == DEPTH drops alloc_ready. Empty: no commit.
- Wrap-around: tags 15 -> 0 are handled purely by modulo arithmetic.
- Reset mid-operation: all state and outputs clear immediately (asynchronous).

Optional Feature:
- ROB_STATS_EN defined: adds outputs stat_commits (32 b, incremented per commit) and stat_flushes (16 b, incremented per mispredict). Both saturate and reset to 0.
- ROB_STATS_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset; alloc tags 0,1,2 with pd_new 33,34,0 and pd_old 5,6,7; complete 2,0,1 -> commits in order 0,1,2 on consecutive cycles; free_en/free_preg = 1/5, 1/6, 0/x.
- Fill 16 entries without completion -> alloc_ready = 0 at count 16. Complete head -> commit, then alloc_ready returns to 1 and the next alloc accepts tag 0 (wrap).
- Alloc tags 0..5 with tag 2 a branch; complete tag 2 with cmpl_mispredict = 1 -> next cycle mispredict = 1, mispredict_tag = 5'd2, tail = 3, entries 3..5 invalid, count = 3.
- Branch at tag 4 completes correct -> hit = 1, hit_tag = 4 for one cycle; mispredict stays 0.
- alloc_tag = 7 while tail = 3 -> tag_err = 1 and stays 1 until reset.
- Assert reset with 5 entries pending -> outputs 0 immediately and alloc_ready = 1 after reset; with ROB_STATS_EN, stat_commits = 0.
